// File: rtl/irq_dispatcher.sv
// Interrupt dispatcher: reads flag/mask registers over Wishbone, hands the
// highest-priority pending source to a handler, then clears its flag bit.
module irq_dispatcher #(
    parameter int          NUM_SOURCES = 4,
    parameter logic [15:0] FLAG_ADR    = 16'h0000,
    parameter logic [15:0] MASK_ADR    = 16'h0002,
    parameter int          TIMEOUT     = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [15:0] wbm_adr_o,
    output logic [15:0] wbm_dat_o,
    input  logic [15:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        irq_i,
    input  logic        enable_i,
    output logic        svc_valid_o,
    output logic [3:0]  svc_id_o,
    input  logic        svc_done_i,
    output logic        busy_o,
    output logic        err_o,
    output logic [7:0]  spurious_cnt_o
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    // Only flag bits [NUM_SOURCES:0] are meaningful; the rest of the bus word is ignored.
    localparam logic [15:0] SRC_MASK = 16'((32'd1 << (NUM_SOURCES + 1)) - 32'd1);

    typedef enum logic [2:0] {
        IDLE,
        RD_FLAG,
        RD_MASK,
        PICK,
        DISPATCH,
        CLEAR,
        HOLDOFF
    } state_t;

    state_t          state, state_next;
    logic [15:0]     flag_q;
    logic [15:0]     mask_q;
    logic [15:0]     pending;
    logic [3:0]      pick_id;
    logic [3:0]      svc_id_q;
    logic [TW-1:0]   tmo_cnt;
    logic [7:0]      spurious_cnt;
    logic            err_q;
    logic            bus_active;
    logic            tmo_hit;

    always_comb begin
        bus_active = (state == RD_FLAG) || (state == RD_MASK) || (state == CLEAR);
        tmo_hit    = bus_active && !wbm_ack_i && (tmo_cnt == TMO_LAST);
        pending    = flag_q & mask_q & SRC_MASK;
    end

    // Lowest index wins, so scan downward and let lower hits overwrite.
    always_comb begin
        pick_id = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (pending[i]) begin
                pick_id = 4'(i);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (irq_i && enable_i) begin
                    state_next = RD_FLAG;
                end
            end
            RD_FLAG: begin
                if (wbm_ack_i) begin
                    state_next = RD_MASK;
                end else if (tmo_hit) begin
                    state_next = HOLDOFF;
                end
            end
            RD_MASK: begin
                if (wbm_ack_i) begin
                    state_next = PICK;
                end else if (tmo_hit) begin
                    state_next = HOLDOFF;
                end
            end
            PICK: begin
                if (pending == 16'd0) begin
                    state_next = HOLDOFF;
                end else begin
                    state_next = DISPATCH;
                end
            end
            DISPATCH: begin
                if (svc_done_i) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                if (wbm_ack_i || tmo_hit) begin
                    state_next = HOLDOFF;
                end
            end
            HOLDOFF: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Every state change starts a fresh bus access window for the timeout.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            tmo_cnt <= '0;
        end else if (state_next != state) begin
            tmo_cnt <= '0;
        end else if (bus_active) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            flag_q <= 16'd0;
            mask_q <= 16'd0;
        end else begin
            if (state == RD_FLAG && wbm_ack_i) begin
                flag_q <= wbm_dat_i;
            end
            if (state == RD_MASK && wbm_ack_i) begin
                mask_q <= wbm_dat_i;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            svc_id_q     <= 4'd0;
            spurious_cnt <= 8'd0;
            err_q        <= 1'b0;
        end else begin
            err_q <= tmo_hit;
            if (state == PICK) begin
                if (pending != 16'd0) begin
                    svc_id_q <= pick_id;
                end else if (spurious_cnt != 8'hFF) begin
                    spurious_cnt <= spurious_cnt + 8'd1;
                end
            end
        end
    end

    // Bus outputs decode straight from the state register so reset kills them at once.
    always_comb begin
        wbm_cyc_o = bus_active;
        wbm_stb_o = bus_active;
        wbm_we_o  = (state == CLEAR);
        wbm_adr_o = 16'd0;
        wbm_dat_o = 16'd0;
        case (state)
            RD_FLAG: wbm_adr_o = FLAG_ADR;
            RD_MASK: wbm_adr_o = MASK_ADR;
            CLEAR: begin
                wbm_adr_o = FLAG_ADR;
                wbm_dat_o = ~(16'd1 << svc_id_q);
            end
            default: wbm_adr_o = 16'd0;
        endcase
    end

    always_comb begin
        busy_o         = (state != IDLE);
        svc_valid_o    = (state == DISPATCH);
        svc_id_o       = svc_id_q;
        err_o          = err_q;
        spurious_cnt_o = spurious_cnt;
    end

endmodule
